id_issue: RTL

Instruction-decode and issue stage for the five-stage integer pipeline. It decodes one 32-bit instruction per cycle into the ALU operation bus (aluop/alusel), operands and destination consumed by the execute stage. It resolves operands from the register file with forwarding from the EX and MEM results, and holds the decoded result in the ID/EX pipeline register under a stall/flush handshake. Coverage is the logic and shift subset; every other encoding issues as a bubble and is counted.

---
 rtl/id_issue.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/id_issue.sv
// Decode/issue stage for the logic and shift subset of the integer pipeline.
// It forwards operands from EX/MEM and holds the result in the ID/EX register under stall/flush.
module id_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid_i,
  input  logic [31:0] inst_i,
  output logic        inst_ready_o,
  output logic        reg1_read_o,
  output logic        reg2_read_o,
  output logic [4:0]  reg1_addr_o,
  output logic [4:0]  reg2_addr_o,
  input  logic [31:0] reg1_data_i,
  input  logic [31:0] reg2_data_i,
  input  logic        ex_wreg_i,
  input  logic [4:0]  ex_wd_i,
  input  logic [31:0] ex_wdata_i,
  input  logic        mem_wreg_i,
  input  logic [4:0]  mem_wd_i,
  input  logic [31:0] mem_wdata_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        valid_o,
  output logic [7:0]  aluop_o,
  output logic [2:0]  alusel_o,
  output logic [31:0] reg1_o,
  output logic [31:0] reg2_o,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [15:0] illegal_cnt_o
);

  localparam logic [7:0] EXE_NOP_OP    = 8'b00000000;
  localparam logic [7:0] EXE_AND_OP    = 8'b00100100;
  localparam logic [7:0] EXE_OR_OP     = 8'b00100101;
  localparam logic [7:0] EXE_XOR_OP    = 8'b00100110;
  localparam logic [7:0] EXE_NOR_OP    = 8'b00100111;
  localparam logic [7:0] EXE_SLL_OP    = 8'b01111100;
  localparam logic [7:0] EXE_SRL_OP    = 8'b00000010;
  localparam logic [7:0] EXE_SRA_OP    = 8'b00000011;
  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

  logic [5:0]  op_s;
  logic [5:0]  funct_s;
  logic [4:0]  rs_s;
  logic [4:0]  rt_s;
  logic [4:0]  rd_s;
  logic [4:0]  sa_s;
  logic [15:0] imm_s;

  logic        legal_s;
  logic        use1_s;
  logic        use2_s;
  logic [7:0]  aluop_s;
  logic [2:0]  alusel_s;
  logic [31:0] k1_s;
  logic [31:0] k2_s;
  logic [4:0]  wd_s;
  logic [31:0] opnd1_s;
  logic [31:0] opnd2_s;
  logic        issue_s;

  logic        valid_r;
  logic [7:0]  aluop_r;
  logic [2:0]  alusel_r;
  logic [31:0] reg1_r;
  logic [31:0] reg2_r;
  logic [4:0]  wd_r;
  logic        wreg_r;
  logic [15:0] cnt_r;

  // The low two bits of funct/opcode select among AND, OR, XOR, NOR.
  function automatic logic [7:0] logic_op(input logic [1:0] sel);
    case (sel)
      2'b00:   logic_op = EXE_AND_OP;
      2'b01:   logic_op = EXE_OR_OP;
      2'b10:   logic_op = EXE_XOR_OP;
      2'b11:   logic_op = EXE_NOR_OP;
      default: logic_op = EXE_NOP_OP;
    endcase
  endfunction

  function automatic logic [7:0] shift_op(input logic [1:0] sel);
    case (sel)
      2'b00:   shift_op = EXE_SLL_OP;
      2'b10:   shift_op = EXE_SRL_OP;
      2'b11:   shift_op = EXE_SRA_OP;
      default: shift_op = EXE_NOP_OP;
    endcase
  endfunction

  // A destination of 0 never forwards because address 0 is resolved first.
  function automatic logic [31:0] resolve(
    input logic [4:0]  addr,
    input logic [31:0] rf_data,
    input logic        ex_we,
    input logic [4:0]  ex_wd,
    input logic [31:0] ex_data,
    input logic        mem_we,
    input logic [4:0]  mem_wd,
    input logic [31:0] mem_data
  );
    if (addr == 5'd0) begin
      resolve = 32'h0;
    end else if (ex_we && (ex_wd == addr)) begin
      resolve = ex_data;
    end else if (mem_we && (mem_wd == addr)) begin
      resolve = mem_data;
    end else begin
      resolve = rf_data;
    end
  endfunction

  assign op_s    = inst_i[31:26];
  assign rs_s    = inst_i[25:21];
  assign rt_s    = inst_i[20:16];
  assign rd_s    = inst_i[15:11];
  assign sa_s    = inst_i[10:6];
  assign funct_s = inst_i[5:0];
  assign imm_s   = inst_i[15:0];

  // Instruction decode: classify the word and pick operand sources.
  always_comb begin
    legal_s  = 1'b0;
    use1_s   = 1'b0;
    use2_s   = 1'b0;
    aluop_s  = EXE_NOP_OP;
    alusel_s = EXE_RES_NOP;
    k1_s     = 32'h0;
    k2_s     = 32'h0;
    wd_s     = 5'd0;
    case (op_s)
      6'b000000: begin
        case (funct_s)
          6'b100100, 6'b100101, 6'b100110, 6'b100111: begin
            legal_s  = (sa_s == 5'd0);
            aluop_s  = logic_op(funct_s[1:0]);
            alusel_s = EXE_RES_LOGIC;
            use1_s   = 1'b1;
            use2_s   = 1'b1;
            wd_s     = rd_s;
          end
          6'b000000, 6'b000010, 6'b000011: begin
            legal_s  = (rs_s == 5'd0);
            aluop_s  = shift_op(funct_s[1:0]);
            alusel_s = EXE_RES_SHIFT;
            k1_s     = {27'b0, sa_s};
            use2_s   = 1'b1;
            wd_s     = rd_s;
          end
          6'b000100, 6'b000110, 6'b000111: begin
            legal_s  = (sa_s == 5'd0);
            aluop_s  = shift_op(funct_s[1:0]);
            alusel_s = EXE_RES_SHIFT;
            use1_s   = 1'b1;
            use2_s   = 1'b1;
            wd_s     = rd_s;
          end
          default: legal_s = 1'b0;
        endcase
      end
      6'b001100, 6'b001101, 6'b001110: begin
        legal_s  = 1'b1;
        aluop_s  = logic_op(op_s[1:0]);
        alusel_s = EXE_RES_LOGIC;
        use1_s   = 1'b1;
        k2_s     = {16'h0, imm_s};
        wd_s     = rt_s;
      end
      6'b001111: begin
        legal_s  = 1'b1;
        aluop_s  = EXE_OR_OP;
        alusel_s = EXE_RES_LOGIC;
        k1_s     = {imm_s, 16'h0};
        wd_s     = rt_s;
      end
      default: legal_s = 1'b0;
    endcase
  end

  assign inst_ready_o = !stall_i;
  assign reg1_read_o  = legal_s & use1_s;
  assign reg2_read_o  = legal_s & use2_s;
  assign reg1_addr_o  = rs_s;
  assign reg2_addr_o  = rt_s;

  assign opnd1_s = use1_s ? resolve(rs_s, reg1_data_i, ex_wreg_i, ex_wd_i, ex_wdata_i,
                                    mem_wreg_i, mem_wd_i, mem_wdata_i) : k1_s;
  assign opnd2_s = use2_s ? resolve(rt_s, reg2_data_i, ex_wreg_i, ex_wd_i, ex_wdata_i,
                                    mem_wreg_i, mem_wd_i, mem_wdata_i) : k2_s;
  assign issue_s = inst_valid_i & legal_s;

  // ID/EX register: flush beats stall, stall holds, otherwise capture or bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r  <= 1'b0;
      aluop_r  <= EXE_NOP_OP;
      alusel_r <= EXE_RES_NOP;
      reg1_r   <= 32'h0;
      reg2_r   <= 32'h0;
      wd_r     <= 5'd0;
      wreg_r   <= 1'b0;
    end else if (flush_i || (!stall_i && !issue_s)) begin
      valid_r  <= 1'b0;
      aluop_r  <= EXE_NOP_OP;
      alusel_r <= EXE_RES_NOP;
      reg1_r   <= 32'h0;
      reg2_r   <= 32'h0;
      wd_r     <= 5'd0;
      wreg_r   <= 1'b0;
    end else if (!stall_i) begin
      valid_r  <= 1'b1;
      aluop_r  <= aluop_s;
      alusel_r <= alusel_s;
      reg1_r   <= opnd1_s;
      reg2_r   <= opnd2_s;
      wd_r     <= wd_s;
      wreg_r   <= (wd_s != 5'd0);
    end else begin
      valid_r  <= valid_r;
      aluop_r  <= aluop_r;
      alusel_r <= alusel_r;
      reg1_r   <= reg1_r;
      reg2_r   <= reg2_r;
      wd_r     <= wd_r;
      wreg_r   <= wreg_r;
    end
  end

  // Saturating count of illegal words that were actually issued as bubbles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= 16'h0;
    end else if (!flush_i && !stall_i && inst_valid_i && !legal_s && (cnt_r != 16'hFFFF)) begin
      cnt_r <= cnt_r + 16'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign valid_o       = valid_r;
  assign aluop_o       = aluop_r;
  assign alusel_o      = alusel_r;
  assign reg1_o        = reg1_r;
  assign reg2_o        = reg2_r;
  assign wd_o          = wd_r;
  assign wreg_o        = wreg_r;
  assign illegal_cnt_o = cnt_r;

endmodule
